gmii_rx_frame_parser: RTL and testbench
=======================================

GMII_RX_FRAME_PARSER -- requirements
Module: gmii_rx_frame_parser

Interface
REQ-001 Parameter LOCAL_MAC_ADDR, default 48'h000a3501fec0: unicast destination address the block accepts.
REQ-002 Parameter MAX_FRAME_LEN, default 11'd1518: longest legal frame, destination MAC through FCS inclusive.
REQ-003 Reset rst_n is asynchronous and active-low; the clock is gmii_rx_clk.
REQ-004 gmii_rx_clk  input  1  receive clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rx_dv  input  1  GMII receive data valid, already registered upstream.
REQ-007 rxd  input  8  GMII receive byte.
REQ-008 rx_frame_start  output  1  one-cycle pulse when the frame's destination MAC is accepted.
REQ-009 rx_dst_mac / rx_src_mac  output  48 each  captured header addresses, held until next frame.
REQ-010 rx_eth_type  output  16  captured EtherType, held until next frame.
REQ-011 rx_data  output  8  payload byte, FCS stripped.
REQ-012 rx_data_valid  output  1  rx_data qualifier.
REQ-013 rx_frame_end  output  1  one-cycle end-of-frame pulse, accepted frames only.
REQ-014 rx_frame_good  output  1  status valid with rx_frame_end: CRC ok, not runt, not oversize.
REQ-015 rx_crc_err / rx_runt / rx_oversize  output  1 each  error flags, valid with rx_frame_end.
REQ-016 rx_payload_len  output  11  payload byte count, valid with rx_frame_end.

Function
REQ-017 FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
REQ-018 IDLE: rx_dv=1 and rxd=8'h55 -> PREAMBLE.
REQ-019 IDLE: rx_dv=1 and any other byte -> DROP.
REQ-020 PREAMBLE: rxd=8'h55 -> stay in PREAMBLE.
REQ-021 PREAMBLE: rxd=8'hD5 (SFD) -> HEADER, byte index N cleared to 0.
REQ-022 PREAMBLE: any other byte -> DROP.
REQ-023 DROP: hold until rx_dv=0, then go to IDLE; no outputs pulse in DROP.
REQ-024 Byte index N counts bytes after the SFD (first destination byte is N=0).
REQ-025 N is 11 bits and saturates at 2047.
REQ-026 Byte mapping: N=0..5 destination MAC, N=6..11 source MAC, N=12..13 EtherType, all MSB-first in wire order.
REQ-027 Address filter is evaluated at N=5.
REQ-028 Accept when the destination equals LOCAL_MAC_ADDR or 48'hFFFFFFFFFFFF; rx_frame_start pulses the cycle after the N=5 byte.
REQ-029 No match -> DROP.
REQ-030 At N=13 -> PAYLOAD.
REQ-031 FCS stripping uses a 4-byte delay line.
REQ-032 The byte at index i (i>=14) is output with rx_data_valid=1 the cycle after byte i+4 is sampled.
REQ-033 The last 4 bytes before rx_dv falls are never emitted.
REQ-034 CRC-32 uses the reflected polynomial 32'hEDB88320, processes LSB-first, and initializes to 32'hFFFFFFFF at SFD.
REQ-035 CRC covers bytes N=0 through the end of frame, FCS included.
REQ-036 crc_ok means the final register equals residue 32'hDEBB20E3.
REQ-037 End of frame is defined as rx_dv=0 while in HEADER or PAYLOAD.
REQ-038 rx_frame_end pulses the next cycle, together with all status outputs.
REQ-039 Total byte count T = N at the end of frame.
REQ-040 rx_runt = (T<64).
REQ-041 rx_oversize = (T>MAX_FRAME_LEN); the oversize frame is still streamed.
REQ-042 rx_crc_err = !crc_ok.
REQ-043 rx_frame_good = !(rx_crc_err | rx_runt | rx_oversize).
REQ-044 rx_payload_len = T-18 when T>=18, else 0.
REQ-045 If rx_dv falls in HEADER after acceptance, rx_frame_end fires with rx_runt=1, rx_frame_good=0, and no data emitted.
REQ-046 If rx_dv reasserts the cycle after the fall, the frame_end cycle also evaluates the IDLE entry condition on that byte, so back-to-back frames are not lost.
REQ-047 Status and data outputs other than held header fields are zero when not qualified.

Reset
REQ-048 While rst_n=0, all outputs are 0, the FSM is in IDLE, the delay line and counters are 0, and the CRC register is 32'hFFFFFFFF.
REQ-049 Reset asserted mid-frame aborts the frame with no rx_frame_end.
REQ-050 After reset release mid-frame, the block waits in DROP until rx_dv=0.

Verification
REQ-051 Scenario: 7x55, D5, 64-byte broadcast frame with valid FCS -> rx_frame_start once; 46 rx_data_valid beats matching bytes 14..59; rx_frame_end with good=1, payload_len=46.
REQ-052 Scenario: same frame with one payload bit flipped -> rx_crc_err=1, rx_frame_good=0, payload still streamed.
REQ-053 Scenario: destination 00:11:22:33:44:55 -> no rx_frame_start, rx_data_valid or rx_frame_end.
REQ-054 Scenario: unicast to LOCAL_MAC_ADDR, T=40 with valid CRC -> rx_runt=1, good=0, payload_len=22.
REQ-055 Scenario: two frames separated by one idle cycle -> two rx_frame_end pulses, both good.
REQ-056 Scenario: rst_n pulsed at N=30 -> outputs 0 immediately, no rx_frame_end; next frame parsed normally.

Source files
------------

// File: rtl/gmii_rx_frame_parser.sv
// gmii_rx_frame_parser
//   Parses GMII receive frames. It checks the preamble and SFD, filters on the
//   destination MAC (local unicast or broadcast), captures the header fields,
//   streams the payload with the 4-byte FCS stripped off, and reports
//   CRC, runt and oversize status at end of frame.
//
// Ports
//   gmii_rx_clk     receive clock; all logic on the rising edge
//   rst_n           asynchronous active-low reset
//   rx_dv, rxd      GMII receive data valid and byte (registered upstream)
//   rx_frame_start  one-cycle pulse when the destination MAC is accepted
//   rx_dst_mac      captured destination address, held until the next frame
//   rx_src_mac      captured source address, held until the next frame
//   rx_eth_type     captured EtherType, held until the next frame
//   rx_data         payload byte with the FCS stripped; qualified by rx_data_valid
//   rx_frame_end    one-cycle end-of-frame pulse, accepted frames only
//   rx_frame_good, rx_crc_err, rx_runt, rx_oversize, rx_payload_len
//                   frame status, valid with rx_frame_end and zero otherwise
module gmii_rx_frame_parser #(
  parameter logic [47:0] LOCAL_MAC_ADDR = 48'h000a3501fec0,
  parameter logic [10:0] MAX_FRAME_LEN  = 11'd1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  output logic        rx_frame_start,
  output logic [47:0] rx_dst_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_eth_type,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_frame_end,
  output logic        rx_frame_good,
  output logic        rx_crc_err,
  output logic        rx_runt,
  output logic        rx_oversize,
  output logic [10:0] rx_payload_len
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] BCAST_ADDR  = 48'hFFFFFFFFFFFF;
  localparam logic [10:0] N_MAX       = 11'd2047;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  // Reflected CRC-32, one byte processed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [10:0]      n_q, n_d;
  logic [31:0]      crc_q, crc_d;
  // Last five header bytes seen; with the current byte this forms a 48-bit address.
  logic [39:0]      hdr_q, hdr_d;
  // FCS-stripping delay line; element [3] is the byte sampled four bytes ago.
  logic [3:0][7:0]  dly_q, dly_d;
  // Set once rx_dv has been seen low since reset, so a frame already in
  // progress when reset releases is ignored rather than parsed from its middle.
  logic             armed_q, armed_d;

  logic             frame_start_q, frame_start_d;
  logic [47:0]      dst_mac_q, dst_mac_d;
  logic [47:0]      src_mac_q, src_mac_d;
  logic [15:0]      eth_type_q, eth_type_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_end_q, frame_end_d;
  logic             frame_good_q, frame_good_d;
  logic             crc_err_q, crc_err_d;
  logic             runt_q, runt_d;
  logic             oversize_q, oversize_d;
  logic [10:0]      payload_len_q, payload_len_d;

  logic [47:0]      hdr_cand;
  logic             runt_w;
  logic             oversize_w;
  logic             crc_err_w;

  assign hdr_cand   = {hdr_q, rxd};
  // At end of frame n_q holds the total byte count, FCS included.
  assign runt_w     = (n_q < 11'd64);
  assign oversize_w = (n_q > MAX_FRAME_LEN);
  assign crc_err_w  = (crc_q != CRC_RESIDUE);

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    crc_d         = crc_q;
    hdr_d         = hdr_q;
    dly_d         = dly_q;
    armed_d       = armed_q | ~rx_dv;
    frame_start_d = 1'b0;
    dst_mac_d     = dst_mac_q;
    src_mac_d     = src_mac_q;
    eth_type_d    = eth_type_q;
    data_d        = 8'h00;
    data_valid_d  = 1'b0;
    frame_end_d   = 1'b0;
    frame_good_d  = 1'b0;
    crc_err_d     = 1'b0;
    runt_d        = 1'b0;
    oversize_d    = 1'b0;
    payload_len_d = 11'd0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          if (armed_q && rxd == 8'h55) state_d = S_PREAMBLE;
          else                         state_d = S_DROP;
        end
      end

      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rxd == 8'h55) begin
          state_d = S_PREAMBLE;
        end else if (rxd == 8'hD5) begin
          state_d = S_HEADER;
          n_d     = 11'd0;
          crc_d   = CRC_INIT;
        end else begin
          state_d = S_DROP;
        end
      end

      S_HEADER, S_PAYLOAD: begin
        if (rx_dv) begin
          crc_d = crc32_byte(crc_q, rxd);
          n_d   = (n_q == N_MAX) ? n_q : n_q + 11'd1;
          hdr_d = {hdr_q[31:0], rxd};
          dly_d = {dly_q[2:0], rxd};
          // Byte n_q-4 leaves the delay line once byte n_q arrives; the first
          // payload byte (index 14) therefore emerges when index 18 is sampled.
          if (n_q >= 11'd18) begin
            data_d       = dly_q[3];
            data_valid_d = 1'b1;
          end
          if (state_q == S_HEADER) begin
            if (n_q == 11'd5) begin
              if (hdr_cand == LOCAL_MAC_ADDR || hdr_cand == BCAST_ADDR) begin
                frame_start_d = 1'b1;
                dst_mac_d     = hdr_cand;
              end else begin
                state_d = S_DROP;
              end
            end
            if (n_q == 11'd11) src_mac_d = hdr_cand;
            if (n_q == 11'd13) begin
              eth_type_d = hdr_cand[15:0];
              state_d    = S_PAYLOAD;
            end
          end
        end else begin
          state_d = S_IDLE;
          // Only frames that passed the address filter (six bytes in) report status.
          if (n_q >= 11'd6) begin
            frame_end_d   = 1'b1;
            crc_err_d     = crc_err_w;
            runt_d        = runt_w;
            oversize_d    = oversize_w;
            frame_good_d  = ~(crc_err_w | runt_w | oversize_w);
            payload_len_d = (n_q >= 11'd18) ? (n_q - 11'd18) : 11'd0;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= 11'd0;
      crc_q         <= CRC_INIT;
      hdr_q         <= '0;
      dly_q         <= '0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
      dst_mac_q     <= '0;
      src_mac_q     <= '0;
      eth_type_q    <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_good_q  <= 1'b0;
      crc_err_q     <= 1'b0;
      runt_q        <= 1'b0;
      oversize_q    <= 1'b0;
      payload_len_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      crc_q         <= crc_d;
      hdr_q         <= hdr_d;
      dly_q         <= dly_d;
      armed_q       <= armed_d;
      frame_start_q <= frame_start_d;
      dst_mac_q     <= dst_mac_d;
      src_mac_q     <= src_mac_d;
      eth_type_q    <= eth_type_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_end_q   <= frame_end_d;
      frame_good_q  <= frame_good_d;
      crc_err_q     <= crc_err_d;
      runt_q        <= runt_d;
      oversize_q    <= oversize_d;
      payload_len_q <= payload_len_d;
    end
  end

  assign rx_frame_start = frame_start_q;
  assign rx_dst_mac     = dst_mac_q;
  assign rx_src_mac     = src_mac_q;
  assign rx_eth_type    = eth_type_q;
  assign rx_data        = data_q;
  assign rx_data_valid  = data_valid_q;
  assign rx_frame_end   = frame_end_q;
  assign rx_frame_good  = frame_good_q;
  assign rx_crc_err     = crc_err_q;
  assign rx_runt        = runt_q;
  assign rx_oversize    = oversize_q;
  assign rx_payload_len = payload_len_q;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Testbench for gmii_rx_frame_parser: table-driven frames with fixed expected
// status, directed multi-cycle sequences, and random frames checked against
// a frame-level reference model.
module tb_gmii_rx_frame_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h000a3501fec0;
  localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER_MAC = 48'h001122334455;
  localparam logic [47:0] SRC_MAC   = 48'h020000000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rx_frame_start;
  logic [47:0] rx_dst_mac;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_eth_type;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_frame_end;
  logic        rx_frame_good;
  logic        rx_crc_err;
  logic        rx_runt;
  logic        rx_oversize;
  logic [10:0] rx_payload_len;

  always #4 clk = ~clk;

  gmii_rx_frame_parser dut (
    .gmii_rx_clk    (clk),
    .rst_n          (rst_n),
    .rx_dv          (rx_dv),
    .rxd            (rxd),
    .rx_frame_start (rx_frame_start),
    .rx_dst_mac     (rx_dst_mac),
    .rx_src_mac     (rx_src_mac),
    .rx_eth_type    (rx_eth_type),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_frame_end   (rx_frame_end),
    .rx_frame_good  (rx_frame_good),
    .rx_crc_err     (rx_crc_err),
    .rx_runt        (rx_runt),
    .rx_oversize    (rx_oversize),
    .rx_payload_len (rx_payload_len)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- output monitor (only writer of these) ----------------
  int          start_cnt = 0;
  int          end_cnt   = 0;
  int          good_cnt  = 0;
  int          qual_bad  = 0;
  logic [7:0]  got_q[$];
  logic        last_good, last_crc, last_runt, last_over;
  logic [10:0] last_len;

  always @(negedge clk) begin
    if (rx_frame_start) start_cnt++;
    if (rx_data_valid) got_q.push_back(rx_data);
    else if (rx_data != 8'h00) qual_bad++;
    if (rx_frame_end) begin
      end_cnt++;
      if (rx_frame_good) good_cnt++;
      last_good = rx_frame_good;
      last_crc  = rx_crc_err;
      last_runt = rx_runt;
      last_over = rx_oversize;
      last_len  = rx_payload_len;
    end else if ({rx_frame_good, rx_crc_err, rx_runt, rx_oversize} != 4'b0 || rx_payload_len != 11'd0) begin
      qual_bad++;
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    int kind;       // 0 broadcast, 1 local unicast, 2 foreign unicast
    int len;        // total bytes after SFD, FCS included
    int corrupt;    // byte index to flip after FCS is computed, -1 for none
    int exp_start;
    int exp_end;
    int exp_good;
    int exp_crc_err;
    int exp_runt;
    int exp_over;
    int exp_plen;
  } vec_t;

  logic [7:0] frame_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc32_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int kind, input int len, input int corrupt);
    logic [47:0] dst;
    logic [31:0] fcs;
    dst = (kind == 0) ? BCAST : (kind == 1) ? LOCAL_MAC : OTHER_MAC;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(SRC_MAC[47-8*i -: 8]);
    frame_q.push_back(8'h08);
    frame_q.push_back(8'h00);
    while (frame_q.size() < len - 4) frame_q.push_back(8'($urandom));
    while (frame_q.size() > len - 4) void'(frame_q.pop_back());
    fcs = crc32_of(len - 4);
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    if (corrupt >= 0) frame_q[corrupt] = frame_q[corrupt] ^ 8'h04;
  endtask

  function automatic logic [47:0] field48(input int base);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v = {v[39:0], frame_q[base+i]};
    return v;
  endfunction

  // Reference model: frame-level rules computed from the wire bytes.
  task automatic model_expect(output vec_t e);
    int len;
    logic [47:0] dst;
    logic [31:0] fcs_rx;
    bit acc, crc_ok;
    len = frame_q.size();
    dst = field48(0);
    acc = (len >= 6) && (dst == LOCAL_MAC || dst == BCAST);
    fcs_rx = {frame_q[len-1], frame_q[len-2], frame_q[len-3], frame_q[len-4]};
    crc_ok = (crc32_of(len - 4) == fcs_rx);
    e.kind = 0; e.len = len; e.corrupt = -1;
    e.exp_start   = acc;
    e.exp_end     = acc;
    e.exp_crc_err = acc && !crc_ok;
    e.exp_runt    = acc && (len < 64);
    e.exp_over    = acc && (len > 1518);
    e.exp_good    = acc && !(e.exp_crc_err || e.exp_runt || e.exp_over);
    e.exp_plen    = (acc && len >= 18) ? len - 18 : 0;
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_dv = v;
    rxd   = b;
  endtask

  task automatic send_frame(input int ifg);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < frame_q.size(); i++) drive(1'b1, frame_q[i]);
    for (int i = 0; i < ifg; i++) drive(1'b0, 8'h00);
  endtask

  task automatic run_and_check(input string tag, input vec_t e);
    int b_start, b_end, b_got, exp_n, got_n, mism, len;
    b_start = start_cnt; b_end = end_cnt; b_got = got_q.size();
    send_frame(3);
    @(negedge clk); #1;
    len = frame_q.size();
    check({tag, ".start"}, 64'(start_cnt - b_start), 64'(e.exp_start));
    check({tag, ".end"},   64'(end_cnt - b_end),     64'(e.exp_end));
    if (e.exp_end != 0 && end_cnt > b_end) begin
      check({tag, ".good"},    64'(last_good), 64'(e.exp_good));
      check({tag, ".crc_err"}, 64'(last_crc),  64'(e.exp_crc_err));
      check({tag, ".runt"},    64'(last_runt), 64'(e.exp_runt));
      check({tag, ".over"},    64'(last_over), 64'(e.exp_over));
      check({tag, ".plen"},    64'(last_len),  64'(e.exp_plen));
    end
    exp_n = (e.exp_start != 0 && len >= 18) ? len - 18 : 0;
    got_n = got_q.size() - b_got;
    check({tag, ".beats"}, 64'(got_n), 64'(exp_n));
    mism = 0;
    if (got_n == exp_n)
      for (int k = 0; k < exp_n; k++) if (got_q[b_got+k] !== frame_q[14+k]) mism++;
    check({tag, ".payload"}, 64'(mism), 64'd0);
    if (e.exp_start != 0 && len >= 14) begin
      check({tag, ".dst"}, 64'(rx_dst_mac), 64'(field48(0)));
      check({tag, ".src"}, 64'(rx_src_mac), 64'(field48(6)));
      check({tag, ".eth"}, 64'(rx_eth_type), 64'({frame_q[12], frame_q[13]}));
    end
    $display("frame %s len=%0d start=%0d end=%0d beats=%0d", tag, len,
             start_cnt - b_start, end_cnt - b_end, got_n);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[10];
  vec_t e;

  initial begin
    int b_start, b_end, b_good, b_got;
    int kind, len, cidx;

    tbl[0] = '{kind:0, len:64,   corrupt:-1, exp_start:1, exp_end:1, exp_good:1, exp_crc_err:0, exp_runt:0, exp_over:0, exp_plen:46};
    tbl[1] = '{kind:0, len:64,   corrupt:20, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:1, exp_runt:0, exp_over:0, exp_plen:46};
    tbl[2] = '{kind:2, len:64,   corrupt:-1, exp_start:0, exp_end:0, exp_good:0, exp_crc_err:0, exp_runt:0, exp_over:0, exp_plen:0};
    tbl[3] = '{kind:1, len:40,   corrupt:-1, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:0, exp_runt:1, exp_over:0, exp_plen:22};
    tbl[4] = '{kind:1, len:63,   corrupt:-1, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:0, exp_runt:1, exp_over:0, exp_plen:45};
    tbl[5] = '{kind:1, len:18,   corrupt:-1, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:0, exp_runt:1, exp_over:0, exp_plen:0};
    tbl[6] = '{kind:1, len:10,   corrupt:-1, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:0, exp_runt:1, exp_over:0, exp_plen:0};
    tbl[7] = '{kind:1, len:1518, corrupt:-1, exp_start:1, exp_end:1, exp_good:1, exp_crc_err:0, exp_runt:0, exp_over:0, exp_plen:1500};
    tbl[8] = '{kind:0, len:1519, corrupt:-1, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:0, exp_runt:0, exp_over:1, exp_plen:1501};
    tbl[9] = '{kind:1, len:64,   corrupt:61, exp_start:1, exp_end:1, exp_good:0, exp_crc_err:1, exp_runt:0, exp_over:0, exp_plen:46};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst.start_end_dv", 64'({rx_frame_start, rx_frame_end, rx_data_valid}), 64'd0);
    check("rst.status", 64'({rx_frame_good, rx_crc_err, rx_runt, rx_oversize, rx_payload_len, rx_data}), 64'd0);
    check("rst.hdr", 64'(rx_dst_mac | rx_src_mac | 48'(rx_eth_type)), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int t = 0; t < 10; t++) begin
      build_frame(tbl[t].kind, tbl[t].len, tbl[t].corrupt);
      run_and_check($sformatf("tbl%0d", t), tbl[t]);
    end

    // Back-to-back frames with a single idle cycle between them
    b_end = end_cnt; b_good = good_cnt;
    build_frame(0, 64, -1);
    send_frame(1);
    build_frame(1, 70, -1);
    send_frame(3);
    @(negedge clk); #1;
    check("b2b.ends",  64'(end_cnt - b_end),   64'd2);
    check("b2b.goods", 64'(good_cnt - b_good), 64'd2);
    $display("frame b2b ends=%0d goods=%0d", end_cnt - b_end, good_cnt - b_good);

    // Reset pulsed while byte N=30 is on the wire
    build_frame(0, 64, -1);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, frame_q[i]);
    @(negedge clk);
    rxd = frame_q[30];
    rst_n = 1'b0;
    #1;
    check("midrst.outs", 64'({rx_frame_start, rx_data_valid, rx_frame_end, rx_data}), 64'd0);
    check("midrst.dst", 64'(rx_dst_mac), 64'd0);
    b_start = start_cnt; b_end = end_cnt; b_got = got_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    rxd = frame_q[31];
    for (int i = 32; i < 64; i++) drive(1'b1, frame_q[i]);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
    @(negedge clk); #1;
    check("midrst.no_end",  64'(end_cnt - b_end), 64'd0);
    check("midrst.no_data", 64'(got_q.size() - b_got), 64'd0);
    check("midrst.no_start", 64'(start_cnt - b_start), 64'd0);
    $display("frame midrst ends=%0d beats=%0d", end_cnt - b_end, got_q.size() - b_got);
    build_frame(0, 64, -1);
    model_expect(e);
    run_and_check("postrst", e);

    // Random frames against the reference model
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(10, 200);
      cidx = ($urandom_range(0, 3) == 0) ? $urandom_range(6, len - 1) : -1;
      build_frame(kind, len, cidx);
      model_expect(e);
      run_and_check($sformatf("rnd%0d", r), e);
    end

    check("qualified_zero", 64'(qual_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
